id_issue_ctrl: RTL and testbench

Decode-stage issue controller sitting between instruction fetch and execute, in front of the immediate generator. It buffers fetched instructions in a 2-entry queue, classifies each opcode into an immediate format select for the generator, and presents instructions to execute under a valid/ready handshake. It serialises M-extension ops by starting the multiply/divide unit and blocking further issue until it reports done. Pipeline flush is supported.

---
 rtl/id_issue_ctrl_pkg.sv | 43 ++++
 rtl/id_issue_ctrl_fmt_decode.sv | 24 ++
 rtl/id_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_id_issue_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// Shared constants and types for the decode-stage issue controller and its
// opcode-to-immediate-format decoder.
package id_issue_ctrl_pkg;

    localparam int unsigned DATAWIDTH_DEF = 32;
    localparam int unsigned INST_W        = 32;
    localparam int unsigned DEPTH         = 2;
    localparam int unsigned CNT_W         = 2;
    localparam int unsigned OPC_W         = 7;
    localparam int unsigned FMT_W         = 3;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [0:0] ST_ISSUE    = 1'b0;
    localparam logic [0:0] ST_WAIT_MDU = 1'b1;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        imm_fmt_e imm_fmt;
        logic     illegal;
        logic     is_mop;
    } fmt_info_t;

endpackage

// File: rtl/id_issue_ctrl_fmt_decode.sv
// Combinational opcode classifier: immediate format, illegal flag and M-op
// detection. Shared with the immediate generator's select logic.
module id_fmt_decode
    import id_issue_ctrl_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    output fmt_info_t         info_c
);

    always_comb begin
        info_c         = '0;
        info_c.imm_fmt = FMT_NONE;
        case (inst[OPC_W-1:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: info_c.imm_fmt = FMT_I;
            OP_STORE:                            info_c.imm_fmt = FMT_S;
            OP_BRANCH:                           info_c.imm_fmt = FMT_B;
            OP_LUI, OP_AUIPC:                    info_c.imm_fmt = FMT_U;
            OP_JAL:                              info_c.imm_fmt = FMT_J;
            OP_REG:                              info_c.is_mop  = (inst[31:25] == FUNCT7_MULDIV);
            default:                             info_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: 2-entry fetch queue, head format decode,
// valid/ready issue to execute and serialisation of M-extension ops.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid,
    input  logic [INST_W-1:0]    if_inst,
    input  logic [DATAWIDTH-1:0] if_pc,
    output logic                 if_ready,
    input  logic                 flush,
    output logic                 id_valid,
    output logic [INST_W-1:0]    id_inst,
    output logic [DATAWIDTH-1:0] id_pc,
    output logic [FMT_W-1:0]     id_imm_fmt,
    output logic                 id_illegal,
    input  logic                 ex_ready,
    output logic                 mdu_start,
    output logic                 mdu_kill,
    input  logic                 mdu_done
);

    logic [INST_W-1:0]    inst_q [DEPTH];
    logic [INST_W-1:0]    inst_d [DEPTH];
    logic [DATAWIDTH-1:0] pc_q   [DEPTH];
    logic [DATAWIDTH-1:0] pc_d   [DEPTH];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [0:0]           state_q, state_d;
    logic                 head_mop_q;
    logic                 start_d, kill_d;
    logic                 push, fire;
    logic [INST_W-1:0]    head_inst_d;
    logic [DATAWIDTH-1:0] head_pc_d;
    fmt_info_t            head_info;

    assign push = if_valid & if_ready;
    assign fire = id_valid & ex_ready;

    // Next-state for queue and FSM; flush overrides everything else.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        start_d  = 1'b0;
        kill_d   = 1'b0;
        if (flush) begin
            state_d  = ST_ISSUE;
            count_d  = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            kill_d   = (state_q == ST_WAIT_MDU);
        end else begin
            if (push) begin
                inst_d[wr_ptr_q] = if_inst;
                pc_d[wr_ptr_q]   = if_pc;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (fire) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                ST_ISSUE: begin
                    if (fire && head_mop_q) begin
                        state_d = ST_WAIT_MDU;
                        start_d = 1'b1;
                    end
                end
                ST_WAIT_MDU: begin
                    if (mdu_done) begin
                        state_d = ST_ISSUE;
                    end
                end
                default: state_d = ST_ISSUE;
            endcase
        end
    end

    // Head outputs are registered from the post-update head entry.
    assign head_inst_d = inst_d[rd_ptr_d];
    assign head_pc_d   = pc_d[rd_ptr_d];

    id_fmt_decode u_head_decode (
        .inst   (head_inst_d),
        .info_c (head_info)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ISSUE;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            inst_q     <= '{default: '0};
            pc_q       <= '{default: '0};
            head_mop_q <= 1'b0;
            if_ready   <= 1'b1;
            id_valid   <= 1'b0;
            id_inst    <= '0;
            id_pc      <= '0;
            id_imm_fmt <= '0;
            id_illegal <= 1'b0;
            mdu_start  <= 1'b0;
            mdu_kill   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            if_ready  <= (count_d < CNT_W'(DEPTH));
            id_valid  <= (count_d != '0) && (state_d == ST_ISSUE);
            mdu_start <= start_d;
            mdu_kill  <= kill_d;
            if (count_d != '0) begin
                id_inst    <= head_inst_d;
                id_pc      <= head_pc_d;
                id_imm_fmt <= FMT_W'(head_info.imm_fmt);
                id_illegal <= head_info.illegal;
                head_mop_q <= head_info.is_mop;
            end
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: issue order and decode checked by a
// scoreboard, control timing checked inline per scenario.
module tb_id_issue_ctrl;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [2:0]  id_imm_fmt;
    logic        id_illegal;
    logic        ex_ready;
    logic        mdu_start;
    logic        mdu_kill;
    logic        mdu_done;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] SW   = 32'h00112023;
    localparam logic [31:0] MUL  = 32'h022080B3;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] JAL  = 32'h0000006F;
    localparam logic [31:0] BEQ  = 32'h00000063;
    localparam logic [31:0] LUI  = 32'h000000B7;
    localparam logic [31:0] BAD  = 32'h0000007F;

    id_issue_ctrl #(.DATAWIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_imm_fmt (id_imm_fmt),
        .id_illegal (id_illegal),
        .ex_ready   (ex_ready),
        .mdu_start  (mdu_start),
        .mdu_kill   (mdu_kill),
        .mdu_done   (mdu_done)
    );

    always #5 clk = ~clk;

    // Reference decode of the opcode table.
    function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.ill  = 1'b0;
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: e.fmt = 3'd1;
            7'h23:                      e.fmt = 3'd2;
            7'h63:                      e.fmt = 3'd3;
            7'h37, 7'h17:               e.fmt = 3'd4;
            7'h6F:                      e.fmt = 3'd5;
            7'h33:                      e.fmt = 3'd0;
            default: begin
                e.fmt = 3'd0;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Scoreboard: every fire must match the oldest accepted instruction.
    always @(negedge clk) begin
        if (rst_n && !flush && id_valid && ex_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL issue_unexpected: got inst=%h pc=%h, expected nothing", id_inst, id_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({id_inst, id_pc, id_imm_fmt, id_illegal} !== {e.inst, e.pc, e.fmt, e.ill})
                    $display("FAIL issue_order: got inst=%h pc=%h fmt=%0d ill=%b, expected inst=%h pc=%h fmt=%0d ill=%b",
                             id_inst, id_pc, id_imm_fmt, id_illegal, e.inst, e.pc, e.fmt, e.ill);
                else
                    n_pass++;
            end
        end
    end

    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl, input logic done);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
        ex_ready = rdy;
        flush    = fl;
        mdu_done = done;
        if (fl) sb.delete();
        else if (v && if_ready) sb.push_back(mk(inst, pc));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [71:0] act;
        rst_n = 1'b0;
        if_valid = 1'b0; if_inst = '0; if_pc = '0;
        flush = 1'b0; ex_ready = 1'b0; mdu_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        act = {if_ready, id_valid, id_inst, id_pc, id_imm_fmt, id_illegal, mdu_start, mdu_kill};
        n_checks++;
        if (act !== {1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_values: got %h, expected %h", act, {1'b1, 71'd0});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, ADDI, 32'h0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({id_valid, id_imm_fmt} !== {1'b1, 3'd1})
            $display("FAIL b2b_first: got valid=%b fmt=%0d, expected valid=1 fmt=1", id_valid, id_imm_fmt);
        else n_pass++;
        cycle(1'b1, SW, 32'h4, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({id_valid, id_imm_fmt} !== {1'b1, 3'd2})
            $display("FAIL b2b_no_bubble: got valid=%b fmt=%0d, expected valid=1 fmt=2", id_valid, id_imm_fmt);
        else n_pass++;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0)
            $display("FAIL b2b_drain: got valid=%b, expected 0", id_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        cycle(1'b1, LUI, 32'h8, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (if_ready !== 1'b1)
            $display("FAIL bp_ready_one: got if_ready=%b, expected 1", if_ready);
        else n_pass++;
        cycle(1'b1, JAL, 32'hC, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (if_ready !== 1'b0)
            $display("FAIL bp_full: got if_ready=%b, expected 0", if_ready);
        else n_pass++;
        cycle(1'b1, BEQ, 32'h10, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({if_ready, id_valid, id_inst} !== {1'b0, 1'b1, LUI})
            $display("FAIL bp_hold: got ready=%b valid=%b inst=%h, expected ready=0 valid=1 inst=%h",
                     if_ready, id_valid, id_inst, LUI);
        else n_pass++;
        cycle(1'b1, BEQ, 32'h10, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({if_ready, id_inst} !== {1'b1, JAL})
            $display("FAIL bp_release: got ready=%b inst=%h, expected ready=1 inst=%h", if_ready, id_inst, JAL);
        else n_pass++;
        cycle(1'b1, BEQ, 32'h10, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mop();
        cycle(1'b1, MUL, 32'h20, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, ADDI, 32'h24, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({mdu_start, id_valid} !== 2'b10)
            $display("FAIL mop_start: got start=%b valid=%b, expected start=1 valid=0", mdu_start, id_valid);
        else n_pass++;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({mdu_start, id_valid} !== 2'b00)
            $display("FAIL mop_start_pulse: got start=%b valid=%b, expected start=0 valid=0", mdu_start, id_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (id_valid !== 1'b0)
                $display("FAIL mop_withheld: got valid=%b at wait %0d, expected 0", id_valid, i);
            else n_pass++;
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({id_valid, id_inst} !== {1'b1, ADDI})
            $display("FAIL mop_resume: got valid=%b inst=%h, expected valid=1 inst=%h", id_valid, id_inst, ADDI);
        else n_pass++;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, ADDI, 32'h28, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (id_valid !== 1'b1)
            $display("FAIL done_in_issue: got valid=%b, expected 1", id_valid);
        else n_pass++;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_flush_wait();
        cycle(1'b1, MUL, 32'h40, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, ADDI, 32'h44, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, SW, 32'h48, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (if_ready !== 1'b0)
            $display("FAIL flush_setup_full: got if_ready=%b, expected 0", if_ready);
        else n_pass++;
        cycle(1'b1, LUI, 32'h4C, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({mdu_kill, id_valid, if_ready, mdu_start} !== 4'b1010)
            $display("FAIL flush_kill: got kill=%b valid=%b ready=%b start=%b, expected kill=1 valid=0 ready=1 start=0",
                     mdu_kill, id_valid, if_ready, mdu_start);
        else n_pass++;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({mdu_kill, id_valid} !== 2'b00)
            $display("FAIL flush_after: got kill=%b valid=%b, expected kill=0 valid=0", mdu_kill, id_valid);
        else n_pass++;
    endtask

    task automatic test_flush_push();
        cycle(1'b1, ADDI, 32'h50, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, SW, 32'h54, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({id_valid, if_ready, mdu_kill} !== 3'b010)
            $display("FAIL flush_issue: got valid=%b ready=%b kill=%b, expected valid=0 ready=1 kill=0",
                     id_valid, if_ready, mdu_kill);
        else n_pass++;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (id_valid !== 1'b0)
            $display("FAIL flush_push_dropped: got valid=%b, expected 0", id_valid);
        else n_pass++;
    endtask

    task automatic test_fmt_sweep();
        logic [31:0] insts [5];
        insts = '{JAL, BEQ, LUI, ADD, BAD};
        for (int i = 0; i < 5; i++)
            cycle(1'b1, insts[i], 32'h100 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [71:0] act;
        cycle(1'b1, MUL, 32'h60, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, ADDI, 32'h64, 1'b1, 1'b0, 1'b0);
        if_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        act = {if_ready, id_valid, id_inst, id_pc, id_imm_fmt, id_illegal, mdu_start, mdu_kill};
        n_checks++;
        if (act !== {1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL async_reset: got %h, expected %h", act, {1'b1, 71'd0});
        else n_pass++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (id_valid !== 1'b0)
            $display("FAIL reset_queue_cleared: got valid=%b, expected 0", id_valid);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_mop();
        test_flush_wait();
        test_flush_push();
        test_fmt_sweep();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
